// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: NOP opcode, FSM
// state encodings, requester-id width and the in-flight tag layout.
package alu_arbiter_pkg;

  localparam logic [5:0] NOP_OP   = 6'b000000;
  localparam int         REQ_ID_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } arb_tag_t;

  localparam int TAG_W = $bits(arb_tag_t);

endpackage

// File: rtl/alu_arbiter_tag_pipe.sv
// Tag delay line that follows each accepted operation through the Execution
// unit, so the returning result can be routed to the requester that issued it.
module arb_ffd #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i) begin
    if (rst_i) q_o <= '0;
    else       q_o <= d_i;
  end
endmodule

module arb_tag_pipe
  import alu_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  arb_tag_t tag_i,
  output arb_tag_t tag_o
);
  logic [TAG_W-1:0] chain [DEPTH+1];

  assign chain[0] = tag_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    arb_ffd #(.W(TAG_W)) u_ffd (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (chain[i]),
      .q_o   (chain[i+1])
    );
  end

  assign tag_o = arb_tag_t'(chain[DEPTH]);
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared Execution unit: round-robin with
// bounded lock ownership, NOP when idle, registered per-requester results.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int LATENCY  = 1,
  parameter int MAX_LOCK = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iReq0,
  input  logic       iReq1,
  input  logic       iLock0,
  input  logic       iLock1,
  input  logic [5:0] iOperation0,
  input  logic [5:0] iOperation1,
  input  logic [9:0] iData0,
  input  logic [9:0] iData1,
  output logic       oGrant0,
  output logic       oGrant1,
  output logic [5:0] oOperation,
  output logic [9:0] oData,
  input  logic [7:0] iResult,
  input  logic       iCarry,
  output logic       oValid0,
  output logic       oValid1,
  output logic [7:0] oResult,
  output logic       oCarry,
  output logic [1:0] oState
);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt0, gnt1, idle_arb;
  logic             valid0_q, valid1_q, carry_q;
  logic [7:0]       result_q;
  arb_tag_t         tag_in, tag_out;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    idle_arb = 1'b0;
    unique case (state_q)
      ST_IDLE: idle_arb = 1'b1;
      ST_OWN0: begin
        if (!iLock0) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          idle_arb = 1'b1;
        end else if (cnt_q == CNT_MAX && iReq1) begin
          // Forced hand-over: the waiting side gets this slot, owner goes next.
          gnt1    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
          rr_d    = 1'b0;
        end else if (iReq0) begin
          gnt0 = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_OWN1: begin
        if (!iLock1) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          idle_arb = 1'b1;
        end else if (cnt_q == CNT_MAX && iReq0) begin
          gnt0    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
          rr_d    = 1'b1;
        end else if (iReq1) begin
          gnt1 = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (idle_arb) begin
      if (iReq0 && (!iReq1 || !rr_q)) gnt0 = 1'b1;
      else if (iReq1)                 gnt1 = 1'b1;
      if (gnt0) begin
        rr_d = 1'b1;
        if (iLock0) begin
          state_d = ST_OWN0;
          cnt_d   = CNT_ONE;
        end
      end
      if (gnt1) begin
        rr_d = 1'b0;
        if (iLock1) begin
          state_d = ST_OWN1;
          cnt_d   = CNT_ONE;
        end
      end
    end

    if (Reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign oGrant0    = gnt0;
  assign oGrant1    = gnt1;
  assign oOperation = gnt0 ? iOperation0 : (gnt1 ? iOperation1 : NOP_OP);
  assign oData      = gnt0 ? iData0 : (gnt1 ? iData1 : 10'd0);
  assign oState     = state_q;

  assign tag_in.valid = gnt0 | gnt1;
  assign tag_in.id    = gnt1;

  arb_tag_pipe #(.DEPTH(LATENCY)) u_tag_pipe (
    .clk_i (Clock),
    .rst_i (Reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      result_q <= 8'd0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      valid0_q <= tag_out.valid && (tag_out.id == 1'b0);
      valid1_q <= tag_out.valid && (tag_out.id == 1'b1);
      if (tag_out.valid) begin
        result_q <= iResult;
        carry_q  <= iCarry;
      end
    end
  end

  assign oValid0 = valid0_q;
  assign oValid1 = valid1_q;
  assign oResult = result_q;
  assign oCarry  = carry_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small Execution stand-in
// (fixed accumulator A=8'hF0, one-cycle result latency).
module tb_alu_arbiter;
  localparam logic [5:0] OP_ADDA = 6'h01;
  localparam logic [5:0] OP_PASS = 6'h02;
  localparam logic [7:0] EXEC_A  = 8'hF0;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iReq0 = 1'b0, iReq1 = 1'b0, iLock0 = 1'b0, iLock1 = 1'b0;
  logic [5:0] iOperation0 = '0, iOperation1 = '0;
  logic [9:0] iData0 = '0, iData1 = '0;
  logic       oGrant0, oGrant1, oValid0, oValid1, oCarry;
  logic [5:0] oOperation;
  logic [9:0] oData;
  logic [7:0] oResult;
  logic [1:0] oState;
  logic [7:0] iResult = '0;
  logic       iCarry = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.LATENCY(1), .MAX_LOCK(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq0(iReq0), .iReq1(iReq1), .iLock0(iLock0), .iLock1(iLock1),
    .iOperation0(iOperation0), .iOperation1(iOperation1),
    .iData0(iData0), .iData1(iData1),
    .oGrant0(oGrant0), .oGrant1(oGrant1),
    .oOperation(oOperation), .oData(oData),
    .iResult(iResult), .iCarry(iCarry),
    .oValid0(oValid0), .oValid1(oValid1),
    .oResult(oResult), .oCarry(oCarry), .oState(oState)
  );

  // clock
  always #5 Clock = ~Clock;

  // Execution stand-in: result of the issued operation is present next cycle
  always @(posedge Clock) begin
    if (oGrant0 || oGrant1) begin
      case (oOperation)
        OP_ADDA: {iCarry, iResult} <= {1'b0, EXEC_A} + {1'b0, oData[7:0]};
        OP_PASS: {iCarry, iResult} <= {oData[8], oData[7:0]};
        default: {iCarry, iResult} <= 9'd0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    iReq0 = 1'b0; iReq1 = 1'b0; iLock0 = 1'b0; iLock1 = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    // reset state, with a request present while Reset is high
    tick();
    tick();
    iReq0 = 1'b1; iOperation0 = OP_ADDA; iData0 = 10'h020;
    #1;
    check_eq("rst_grant0", oGrant0, 0);
    check_eq("rst_grant1", oGrant1, 0);
    check_eq("rst_op", oOperation, 0);
    check_eq("rst_valid0", oValid0, 0);
    check_eq("rst_valid1", oValid1, 0);
    check_eq("rst_result", oResult, 0);
    check_eq("rst_carry", oCarry, 0);
    check_eq("rst_state", oState, 0);

    // single request: F0 + 20 = 1_10
    Reset = 1'b0;
    #1;
    check_eq("single_grant0", oGrant0, 1);
    check_eq("single_grant1", oGrant1, 0);
    check_eq("single_op", oOperation, OP_ADDA);
    check_eq("single_data", oData, 10'h020);
    tick();
    iReq0 = 1'b0;
    #1;
    check_eq("single_v0_early", oValid0, 0);
    tick();
    check_eq("single_v0", oValid0, 1);
    check_eq("single_v1", oValid1, 0);
    check_eq("single_result", oResult, 8'h10);
    check_eq("single_carry", oCarry, 1);
    tick();
    check_eq("single_v0_pulse", oValid0, 0);
    check_eq("single_hold", oResult, 8'h10);

    // contention, locks low: 0,1,0,1
    do_reset();
    iOperation0 = OP_PASS; iData0 = 10'h155;
    iOperation1 = OP_PASS; iData1 = 10'h0AA;
    for (int c = 0; c < 7; c++) begin
      iReq0 = (c < 4); iReq1 = (c < 4);
      #1;
      check_eq("cont_grant0", oGrant0, (c < 4) && (c % 2 == 0));
      check_eq("cont_grant1", oGrant1, (c < 4) && (c % 2 == 1));
      check_eq("cont_valid0", oValid0, (c >= 2) && (c < 6) && (c % 2 == 0));
      check_eq("cont_valid1", oValid1, (c >= 2) && (c < 6) && (c % 2 == 1));
      if (c >= 2 && c < 6)
        check_eq("cont_result", oResult, (c % 2 == 0) ? 8'h55 : 8'hAA);
      tick();
    end

    // lock limit: 8 locked grants to 0, then 1, then back to arbitration
    do_reset();
    iOperation0 = OP_PASS; iData0 = 10'h133;
    iOperation1 = OP_PASS; iData1 = 10'h0CC;
    iLock0 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      iReq0 = 1'b1; iReq1 = (c >= 2);
      #1;
      check_eq("lock_grant0", oGrant0, c != 8);
      check_eq("lock_grant1", oGrant1, c == 8);
      if (c == 8) check_eq("lock_state_own0", oState, 1);
      if (c == 9) check_eq("lock_state_idle", oState, 0);
      if (c == 10) begin
        check_eq("lock_valid1", oValid1, 1);
        check_eq("lock_result1", oResult, 8'hCC);
        check_eq("lock_carry1", oCarry, 0);
      end
      tick();
    end
    iReq0 = 1'b0; iReq1 = 1'b0; iLock0 = 1'b0;
    tick();
    tick();

    // idle: NOP on the bus, no pulses, result held
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("idle_op", oOperation, 0);
      check_eq("idle_data", oData, 0);
      check_eq("idle_valid0", oValid0, 0);
      check_eq("idle_valid1", oValid1, 0);
      check_eq("idle_result", oResult, 8'h33);
      tick();
    end

    // reset while an operation is in flight
    iReq0 = 1'b1; iData0 = 10'h1FF;
    #1;
    check_eq("mid_grant0", oGrant0, 1);
    tick();
    iReq0 = 1'b0; Reset = 1'b1;
    #1;
    check_eq("mid_rst_grant0", oGrant0, 0);
    check_eq("mid_rst_op", oOperation, 0);
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("mid_valid0", oValid0, 0);
      check_eq("mid_valid1", oValid1, 0);
      check_eq("mid_result", oResult, 0);
      check_eq("mid_carry", oCarry, 0);
      tick();
    end
    iReq0 = 1'b1; iReq1 = 1'b1; iData1 = 10'h042;
    #1;
    check_eq("post_grant0", oGrant0, 1);
    check_eq("post_grant1", oGrant1, 0);
    tick();
    iReq0 = 1'b0; iReq1 = 1'b0;
    tick();
    check_eq("post_valid0", oValid0, 1);
    check_eq("post_result", oResult, 8'hFF);
    check_eq("post_carry", oCarry, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, cycles from the issue edge until the Execution unit's oResult/oCarry are valid.
REQ-002 Parameter MAX_LOCK, default 8, the most consecutive locked grants allowed while the other requester waits.
REQ-003 Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 iReq0 / iReq1  input  1 each  request to issue one operation this cycle.
REQ-006 iLock0 / iLock1  input  1 each  request to keep ownership for back-to-back issues.
REQ-007 iOperation0 / iOperation1  input  6 each  opcode from the requester.
REQ-008 iData0 / iData1  input  10 each  constant operand from the requester.
REQ-009 oGrant0 / oGrant1  output  1 each  combinational; the operation is accepted at the next rising edge.
REQ-010 oOperation  output  6  opcode driven to Execution.iOperation_ID.
REQ-011 oData  output  10  operand driven to Execution.iData_ID.
REQ-012 iResult  input  8  from Execution.oResult.
REQ-013 iCarry  input  1  from Execution.oCarry.
REQ-014 oValid0 / oValid1  output  1 each  registered; result for that requester is present this cycle.
REQ-015 oResult  output  8  registered result.
REQ-016 oCarry  output  1  registered carry.

Function
REQ-017 At most one of oGrant0/oGrant1 shall be high in any cycle.
REQ-018 No grant: oOperation shall be the NOP opcode (6'b000000) and oData shall be 0.
REQ-019 Grant: oOperation/oData shall be the granted requester's inputs, combinationally.
REQ-020 A grant shall be issued only to a requester whose iReq is high.
REQ-021 FSM states: IDLE, OWN0, OWN1.
REQ-022 IDLE:
- single requester: granted.
- both requesting: the requester selected by rr_ptr is granted.
- after any IDLE grant, rr_ptr shall point to the other requester.
REQ-023 IDLE to OWNn when requester n is granted with iLockn high; the lock counter loads 1.
REQ-024 OWNn:
- requester n is granted whenever iReqn is high; each grant increments the lock counter.
- iReqn low with iLockn high: no grant, state held.
REQ-025 OWNn to IDLE when iLockn is low; that same cycle shall be arbitrated with the IDLE rules.
REQ-026 OWNn to IDLE when the lock counter equals MAX_LOCK and the other requester is requesting.
- That cycle, the other requester shall be granted and rr_ptr shall point to n.
REQ-027 A tag pipeline of depth LATENCY shall carry {valid, requester id} for every accepted operation.
REQ-028 Result capture: at the edge where a tag exits the pipeline, oResult=iResult and oCarry=iCarry shall be registered, and the matching oValidn shall be set high for exactly one cycle.
REQ-029 End-to-end latency: acceptance edge k, oValid high in the cycle after edge k+LATENCY (2 cycles with LATENCY=1).
REQ-030 Back-to-back accepted operations shall produce results on consecutive cycles with no bubble.
REQ-031 With no valid tag exiting, oValid0/oValid1 shall be 0; oResult/oCarry shall hold their previous values.
REQ-032 8-bit widths and carry shall pass through unmodified; the arbiter performs no arithmetic.

Reset
REQ-033 On Reset high at a rising edge:
- state=IDLE, rr_ptr=0, lock counter=0, all tag valid bits=0.
- oValid0=oValid1=0, oResult=0, oCarry=0.
REQ-034 While Reset is high, oGrant0/oGrant1 shall be 0 and oOperation shall be NOP.
REQ-035 Operations in flight when Reset asserts shall be discarded and shall never raise oValid.

Structure
REQ-036 The shared opcode package/include shall hold the NOP opcode, the FSM state encodings, and the requester-id width.
REQ-037 The tag pipeline shall be one sub-module, arb_tag_pipe (parameterised depth, built from FFD instances).
REQ-038 The Execution instance shall be outside this block.

Verification
REQ-039 Single request: iReq0=1 with ADDA, A=8'hF0, B=8'h20 -> oGrant0=1 same cycle; oValid0=1 two cycles later with oResult=8'h10, oCarry=1.
REQ-040 Contention: iReq0=iReq1=1 held for 4 cycles, locks low -> grants alternate 0,1,0,1; oValid alternates 0,1,0,1 two cycles later.
REQ-041 Lock limit: iLock0=iReq0=1 continuously, iReq1=1 from cycle 2, MAX_LOCK=8 -> exactly 8 consecutive oGrant0, then oGrant1, then the FSM returns to IDLE arbitration.
REQ-042 Idle: no requests for 5 cycles -> oOperation=6'b0, oData=0, no oValid pulses, oResult unchanged.
REQ-043 Reset mid-flight: grant at edge k, Reset high at edge k+1 -> no oValid at any time; oResult=0; next request is served normally with rr_ptr=0.
